// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined MIPS core.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  // Writeback source select carried down from decode
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_LUI = 2'b10,
    WB_PC4 = 2'b11
  } wbsel_t;

  // Data-cache access sequencing in the MEM stage
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } memstate_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-cache request/response bus between the MEM stage and the cache.
interface mem_wb_stage_if;
  import cpu_types_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dmemload;

  // Pipeline side issues requests
  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  // Cache side answers them
  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );

endinterface

// File: rtl/mem_wb_stage_fsm.sv
// Data-cache access sequencer: issues one request per instruction, holds it
// until dhit, keeps the load data, and stalls the pipeline meanwhile.
module dmem_access_fsm
  import cpu_types_pkg::*;
(
  input  logic   CLK,
  input  logic   nRST,
  input  logic   memop,
  input  logic   ex_dREN,
  input  logic   ex_dWEN,
  input  word_t  ex_alu,
  input  word_t  ex_store,
  input  logic   adv,
  mem_wb_stage_if.master dcif,
  output logic   mem_stall,
  output logic   done,
  output word_t  ldata
);

  memstate_t state;
  logic      req;

  // Request is live only before completion; reset drops it immediately
  always_comb begin
    req            = memop & (state != DONE) & nRST;
    dcif.dmemWEN   = req & ex_dWEN;
    dcif.dmemREN   = req & ex_dREN & ~ex_dWEN;
    dcif.dmemaddr  = ex_alu;
    dcif.dmemstore = ex_store;
    mem_stall      = req;
    done           = (state == DONE);
  end

  // Access state and captured load data
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      ldata <= '0;
    end else begin
      if (req && dcif.dhit)
        ldata <= dcif.dmemload;
      unique case (state)
        IDLE: if (memop) state <= dcif.dhit ? DONE : WAIT;
        WAIT: if (dcif.dhit) state <= DONE;
        DONE: if (adv) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register: sequences the data-cache access,
// selects the writeback value and latches it toward the register file.
module mem_wb_stage
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     ihit,
  input  logic     ex_valid,
  input  regbits_t ex_rd,
  input  logic     ex_dREN,
  input  logic     ex_dWEN,
  input  word_t    ex_store,
  input  logic     ex_regWr,
  input  logic [1:0] ex_wbsel,
  input  logic     ex_halt,
  input  word_t    ex_alu,
  input  word_t    ex_lui,
  input  word_t    ex_pc4,
  mem_wb_stage_if.master dcif,
  output logic     mem_stall,
  output logic     wb_valid,
  output logic     wb_WEN,
  output regbits_t wb_wsel,
  output word_t    wb_wdat,
  output logic     halt
);

  logic  memop;
  logic  adv;
  logic  done;
  word_t ldata;
  word_t wdat_sel;

  assign memop = ex_valid & (ex_dREN | ex_dWEN) & ~halt;
  assign adv   = ihit & ~mem_stall & ~halt;

  dmem_access_fsm u_fsm (
    .CLK       (CLK),
    .nRST      (nRST),
    .memop     (memop),
    .ex_dREN   (ex_dREN),
    .ex_dWEN   (ex_dWEN),
    .ex_alu    (ex_alu),
    .ex_store  (ex_store),
    .adv       (adv),
    .dcif      (dcif),
    .mem_stall (mem_stall),
    .done      (done),
    .ldata     (ldata)
  );

  // Writeback source mux; a completed access supplies its held load data
  always_comb begin
    wdat_sel = ex_alu;
    unique case (wbsel_t'(ex_wbsel))
      WB_ALU: wdat_sel = ex_alu;
      WB_MEM: wdat_sel = done ? ldata : dcif.dmemload;
      WB_LUI: wdat_sel = ex_lui;
      WB_PC4: wdat_sel = ex_pc4;
    endcase
  end

  // MEM/WB register, advancing only when the pipeline moves
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      wb_valid <= 1'b0;
      wb_WEN   <= 1'b0;
      wb_wsel  <= '0;
      wb_wdat  <= '0;
    end else if (adv) begin
      wb_valid <= ex_valid;
      wb_WEN   <= ex_valid & ex_regWr & (ex_rd != '0);
      wb_wsel  <= ex_rd;
      wb_wdat  <= wdat_sel;
    end
  end

  // Sticky halt once a halt instruction retires through MEM
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST)
      halt <= 1'b0;
    else if (adv && ex_valid && ex_halt)
      halt <= 1'b1;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
module tb_mem_wb_stage;
  import cpu_types_pkg::*;

  logic       CLK;
  logic       nRST;
  logic       ihit;
  logic       ex_valid;
  logic [4:0] ex_rd;
  logic       ex_dREN;
  logic       ex_dWEN;
  logic [31:0] ex_store;
  logic       ex_regWr;
  logic [1:0] ex_wbsel;
  logic       ex_halt;
  logic [31:0] ex_alu;
  logic [31:0] ex_lui;
  logic [31:0] ex_pc4;
  logic       mem_stall;
  logic       wb_valid;
  logic       wb_WEN;
  logic [4:0] wb_wsel;
  logic [31:0] wb_wdat;
  logic       halt;

  int tests = 0;
  int fails = 0;

  mem_wb_stage_if dcif ();

  mem_wb_stage dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .ihit      (ihit),
    .ex_valid  (ex_valid),
    .ex_rd     (ex_rd),
    .ex_dREN   (ex_dREN),
    .ex_dWEN   (ex_dWEN),
    .ex_store  (ex_store),
    .ex_regWr  (ex_regWr),
    .ex_wbsel  (ex_wbsel),
    .ex_halt   (ex_halt),
    .ex_alu    (ex_alu),
    .ex_lui    (ex_lui),
    .ex_pc4    (ex_pc4),
    .dcif      (dcif.master),
    .mem_stall (mem_stall),
    .wb_valid  (wb_valid),
    .wb_WEN    (wb_WEN),
    .wb_wsel   (wb_wsel),
    .wb_wdat   (wb_wdat),
    .halt      (halt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ex();
    ihit = 0; ex_valid = 0; ex_rd = '0; ex_dREN = 0; ex_dWEN = 0;
    ex_store = '0; ex_regWr = 0; ex_wbsel = 2'b00; ex_halt = 0;
    ex_alu = '0; ex_lui = '0; ex_pc4 = '0;
    dcif.dhit = 0; dcif.dmemload = '0;
  endtask

  task automatic test_reset();
    clear_ex();
    nRST = 0;
    ex_valid = 1; ex_dREN = 1; ex_dWEN = 1; ihit = 1; dcif.dhit = 1;
    #2;
    tests++; if (dcif.dmemREN !== 1'b0) begin fails++; $display("FAIL rst_ren: got %b want 0", dcif.dmemREN); end
    tests++; if (dcif.dmemWEN !== 1'b0) begin fails++; $display("FAIL rst_wen: got %b want 0", dcif.dmemWEN); end
    tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", mem_stall); end
    tick();
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
    tests++; if (wb_WEN !== 1'b0) begin fails++; $display("FAIL rst_wb_WEN: got %b want 0", wb_WEN); end
    tests++; if (wb_wsel !== 5'd0) begin fails++; $display("FAIL rst_wb_wsel: got %0d want 0", wb_wsel); end
    tests++; if (wb_wdat !== 32'h0) begin fails++; $display("FAIL rst_wb_wdat: got %h want 0", wb_wdat); end
    tests++; if (halt !== 1'b0) begin fails++; $display("FAIL rst_halt: got %b want 0", halt); end
    clear_ex();
    nRST = 1;
    tick();
  endtask

  task automatic test_alu();
    clear_ex();
    ex_valid = 1; ex_wbsel = 2'b00; ex_alu = 32'h1234; ex_rd = 5'd5; ex_regWr = 1; ihit = 1;
    #1;
    tests++; if ({dcif.dmemREN, dcif.dmemWEN} !== 2'b00) begin fails++; $display("FAIL alu_req: got %b want 00", {dcif.dmemREN, dcif.dmemWEN}); end
    tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL alu_stall: got %b want 0", mem_stall); end
    tick();
    tests++; if (wb_wdat !== 32'h1234) begin fails++; $display("FAIL alu_wdat: got %h want 00001234", wb_wdat); end
    tests++; if (wb_wsel !== 5'd5) begin fails++; $display("FAIL alu_wsel: got %0d want 5", wb_wsel); end
    tests++; if ({wb_valid, wb_WEN} !== 2'b11) begin fails++; $display("FAIL alu_valid_wen: got %b want 11", {wb_valid, wb_WEN}); end
    clear_ex();
  endtask

  task automatic test_load();
    int stall_cnt = 0;
    clear_ex();
    ex_valid = 1; ex_dREN = 1; ex_alu = 32'h80; ex_wbsel = 2'b01; ex_rd = 5'd7; ex_regWr = 1; ihit = 1;
    for (int k = 0; k < 10; k++) begin
      dcif.dhit = (k == 3);
      dcif.dmemload = (k == 3) ? 32'hDEADBEEF : 32'h0;
      #1;
      if (k == 0) begin
        tests++; if (dcif.dmemREN !== 1'b1 || dcif.dmemaddr !== 32'h80) begin fails++; $display("FAIL load_req: got ren=%b addr=%h want ren=1 addr=00000080", dcif.dmemREN, dcif.dmemaddr); end
      end
      if (!mem_stall) break;
      stall_cnt++;
      tick();
    end
    tests++; if (stall_cnt != 4) begin fails++; $display("FAIL load_stall_cycles: got %0d want 4", stall_cnt); end
    tests++; if (dcif.dmemREN !== 1'b0) begin fails++; $display("FAIL load_done_noreq: got %b want 0", dcif.dmemREN); end
    tick();
    tests++; if (wb_wdat !== 32'hDEADBEEF) begin fails++; $display("FAIL load_wdat: got %h want deadbeef", wb_wdat); end
    tests++; if (wb_wsel !== 5'd7 || wb_WEN !== 1'b1) begin fails++; $display("FAIL load_wsel_wen: got %0d/%b want 7/1", wb_wsel, wb_WEN); end
    clear_ex();
  endtask

  task automatic test_store_ihit_low();
    int wen_cyc = 0;
    int writes = 0;
    clear_ex();
    ex_valid = 1; ex_dWEN = 1; ex_dREN = 1; ex_alu = 32'h100; ex_store = 32'hCAFE0001; ex_rd = 5'd2;
    for (int k = 0; k < 8; k++) begin
      ihit = (k == 7);
      dcif.dhit = (k >= 1);
      #1;
      if (dcif.dmemWEN) wen_cyc++;
      if (dcif.dmemWEN && dcif.dhit) writes++;
      if (k == 0) begin
        tests++; if (dcif.dmemstore !== 32'hCAFE0001 || dcif.dmemREN !== 1'b0) begin fails++; $display("FAIL store_req: got data=%h ren=%b want cafe0001/0", dcif.dmemstore, dcif.dmemREN); end
      end
      if (k >= 2 && k < 7) begin
        tests++; if (mem_stall !== 1'b0 || wb_wsel !== 5'd7) begin fails++; $display("FAIL store_done_hold k=%0d: got stall=%b wsel=%0d want 0/7", k, mem_stall, wb_wsel); end
      end
      tick();
    end
    tests++; if (wen_cyc != 2) begin fails++; $display("FAIL store_wen_cycles: got %0d want 2", wen_cyc); end
    tests++; if (writes != 1) begin fails++; $display("FAIL store_writes: got %0d want 1", writes); end
    tests++; if ({wb_valid, wb_WEN, wb_wsel} !== {1'b1, 1'b0, 5'd2}) begin fails++; $display("FAIL store_adv: got v=%b wen=%b wsel=%0d want 1/0/2", wb_valid, wb_WEN, wb_wsel); end
    clear_ex();
  endtask

  task automatic test_dhit_ihit_same();
    clear_ex();
    ex_valid = 1; ex_dREN = 1; ex_alu = 32'h200; ex_wbsel = 2'b01; ex_rd = 5'd4; ex_regWr = 1;
    ihit = 1; dcif.dhit = 1; dcif.dmemload = 32'h11112222;
    #1;
    tests++; if (mem_stall !== 1'b1 || dcif.dmemREN !== 1'b1) begin fails++; $display("FAIL same_stall: got stall=%b ren=%b want 1/1", mem_stall, dcif.dmemREN); end
    tick();
    dcif.dhit = 0; dcif.dmemload = 32'h33334444;
    #1;
    tests++; if (wb_wsel !== 5'd2 || mem_stall !== 1'b0 || dcif.dmemREN !== 1'b0) begin fails++; $display("FAIL same_noadv: got wsel=%0d stall=%b ren=%b want 2/0/0", wb_wsel, mem_stall, dcif.dmemREN); end
    tick();
    tests++; if (wb_wdat !== 32'h11112222 || wb_wsel !== 5'd4) begin fails++; $display("FAIL same_held_ldata: got %h/%0d want 11112222/4", wb_wdat, wb_wsel); end
    clear_ex();
  endtask

  task automatic test_rd0_bubble();
    clear_ex();
    ex_valid = 1; ex_regWr = 1; ex_rd = 5'd0; ex_wbsel = 2'b10; ex_lui = 32'hABCD0000; ihit = 1;
    tick();
    tests++; if ({wb_valid, wb_WEN} !== 2'b10 || wb_wdat !== 32'hABCD0000) begin fails++; $display("FAIL rd0: got v=%b wen=%b wdat=%h want 1/0/abcd0000", wb_valid, wb_WEN, wb_wdat); end
    ex_rd = 5'd31; ex_wbsel = 2'b11; ex_pc4 = 32'h44;
    tick();
    tests++; if (wb_WEN !== 1'b1 || wb_wdat !== 32'h44 || wb_wsel !== 5'd31) begin fails++; $display("FAIL pc4: got wen=%b wdat=%h wsel=%0d want 1/00000044/31", wb_WEN, wb_wdat, wb_wsel); end
    ex_valid = 0; ex_rd = 5'd3;
    tick();
    tests++; if ({wb_valid, wb_WEN} !== 2'b00) begin fails++; $display("FAIL bubble: got v=%b wen=%b want 0/0", wb_valid, wb_WEN); end
    clear_ex();
  endtask

  task automatic test_reset_mid_access();
    clear_ex();
    ex_valid = 1; ex_dREN = 1; ex_alu = 32'h300; ex_wbsel = 2'b01; ex_rd = 5'd6; ex_regWr = 1; ihit = 1;
    tick();
    tests++; if (dcif.dmemREN !== 1'b1 || mem_stall !== 1'b1) begin fails++; $display("FAIL midrst_wait: got ren=%b stall=%b want 1/1", dcif.dmemREN, mem_stall); end
    nRST = 0;
    #1;
    tests++; if ({dcif.dmemREN, dcif.dmemWEN, mem_stall} !== 3'b000) begin fails++; $display("FAIL midrst_drop: got %b want 000", {dcif.dmemREN, dcif.dmemWEN, mem_stall}); end
    tests++; if ({wb_valid, wb_WEN, wb_wsel, wb_wdat, halt} !== '0) begin fails++; $display("FAIL midrst_outs: got v=%b wen=%b wsel=%0d wdat=%h halt=%b want all 0", wb_valid, wb_WEN, wb_wsel, wb_wdat, halt); end
    tick();
    nRST = 1;
    #1;
    tests++; if (dcif.dmemREN !== 1'b1 || dcif.dmemaddr !== 32'h300) begin fails++; $display("FAIL midrst_reissue: got ren=%b addr=%h want 1/00000300", dcif.dmemREN, dcif.dmemaddr); end
    dcif.dhit = 1; dcif.dmemload = 32'h55;
    tick();
    dcif.dhit = 0;
    tick();
    tests++; if (wb_wdat !== 32'h55 || wb_wsel !== 5'd6) begin fails++; $display("FAIL midrst_result: got %h/%0d want 00000055/6", wb_wdat, wb_wsel); end
    clear_ex();
  endtask

  task automatic test_halt();
    clear_ex();
    ex_valid = 1; ex_halt = 1; ihit = 1; ex_rd = 5'd8; ex_regWr = 1; ex_alu = 32'h77;
    tick();
    tests++; if (halt !== 1'b1 || wb_wsel !== 5'd8 || wb_wdat !== 32'h77) begin fails++; $display("FAIL halt_set: got halt=%b wsel=%0d wdat=%h want 1/8/00000077", halt, wb_wsel, wb_wdat); end
    clear_ex();
    ex_valid = 1; ex_dREN = 1; ex_dWEN = 1; ex_rd = 5'd9; ex_regWr = 1; ex_wbsel = 2'b01;
    ex_alu = 32'h400; ihit = 1; dcif.dhit = 1; dcif.dmemload = 32'h99;
    #1;
    tests++; if ({dcif.dmemREN, dcif.dmemWEN, mem_stall} !== 3'b000) begin fails++; $display("FAIL halt_noreq: got %b want 000", {dcif.dmemREN, dcif.dmemWEN, mem_stall}); end
    tick(); tick(); tick();
    tests++; if (halt !== 1'b1) begin fails++; $display("FAIL halt_sticky: got %b want 1", halt); end
    tests++; if (wb_wsel !== 5'd8 || wb_wdat !== 32'h77 || wb_valid !== 1'b1) begin fails++; $display("FAIL halt_frozen: got wsel=%0d wdat=%h v=%b want 8/00000077/1", wb_wsel, wb_wdat, wb_valid); end
    clear_ex();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_ihit_low();
    test_dhit_ihit_same();
    test_rd0_bubble();
    test_reset_mid_access();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
